// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexes a 16-bit hex value across a 4-digit
// common-anode display. Loads are double-buffered in shadow registers and
// only become visible at a frame boundary, so a frame never mixes old and
// new digits. All outputs are registered and follow next-state slot/data.
module sevenseg_scan #(
  parameter int DIV_WIDTH = 17,
  parameter int DIV_MAX   = 99999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        blank_lz,
  input  logic        load,
  output logic        pending,
  output logic [3:0]  digit,
  output logic [3:0]  anode,
  output logic        dp,
  output logic        frame_tick
);

  localparam logic [DIV_WIDTH-1:0] DIV_TC  = DIV_WIDTH'(DIV_MAX);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
  logic [1:0]           sel_reg, sel_next;
  logic                 tick;
  logic                 boundary;

  logic [15:0] act_value_reg, act_value_next;
  logic [3:0]  act_dp_reg, act_dp_next;
  logic [3:0]  act_en_reg, act_en_next;
  logic [15:0] shd_value_reg, shd_value_next;
  logic [3:0]  shd_dp_reg, shd_dp_next;
  logic [3:0]  shd_en_reg, shd_en_next;
  logic        pending_reg, pending_next;

  logic [3:0]  digit_reg, digit_next;
  logic [3:0]  anode_reg, anode_next;
  logic        dp_reg, dp_next;
  logic        frame_tick_reg, frame_tick_next;

  // Per-digit leading-zero flag and visibility, derived from the data that
  // will be active after this edge so the outputs never lag a transfer.
  logic [3:0]  lz;
  logic [3:0]  vis;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_vis
      if (gi == 0) begin : g_lsd
        // The rightmost digit always shows, so a zero value displays "0".
        assign lz[gi] = 1'b0;
      end else begin : g_upper
        assign lz[gi] = (act_value_next[15:4*gi] == '0);
      end
      assign vis[gi] = act_en_next[gi] & ~(blank_lz & lz[gi]);
    end
  endgenerate

  // Refresh prescaler and slot index; a frame ends when slot 3 expires.
  always_comb begin
    tick     = (cnt_reg == DIV_TC);
    cnt_next = tick ? '0 : cnt_reg + DIV_ONE;
    sel_next = tick ? sel_reg + 2'd1 : sel_reg;
    boundary = tick && (sel_reg == 2'd3);
  end

  // Shadow capture and frame-boundary transfer; a load on the boundary
  // cycle bypasses the shadow and goes straight to the active set.
  always_comb begin
    act_value_next = act_value_reg;
    act_dp_next    = act_dp_reg;
    act_en_next    = act_en_reg;
    shd_value_next = shd_value_reg;
    shd_dp_next    = shd_dp_reg;
    shd_en_next    = shd_en_reg;
    pending_next   = pending_reg;
    if (boundary) begin
      if (load) begin
        act_value_next = value;
        act_dp_next    = dp_in;
        act_en_next    = digit_en;
      end else if (pending_reg) begin
        act_value_next = shd_value_reg;
        act_dp_next    = shd_dp_reg;
        act_en_next    = shd_en_reg;
      end
      pending_next = 1'b0;
    end else if (load) begin
      shd_value_next = value;
      shd_dp_next    = dp_in;
      shd_en_next    = digit_en;
      pending_next   = 1'b1;
    end
  end

  // Output decode: refreshed only on slot ticks so the display holds steady
  // within a slot; frame_tick marks the 3 -> 0 wrap.
  always_comb begin
    digit_next      = digit_reg;
    anode_next      = anode_reg;
    dp_next         = dp_reg;
    frame_tick_next = boundary;
    if (tick) begin
      digit_next = act_value_next[4*sel_next +: 4];
      anode_next = vis[sel_next] ? ~(4'b0001 << sel_next) : 4'hF;
      dp_next    = vis[sel_next] ? ~act_dp_next[sel_next] : 1'b1;
    end
  end

  // State registers; reset darkens the display and discards pending data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      sel_reg        <= 2'd0;
      act_value_reg  <= 16'h0000;
      act_dp_reg     <= 4'h0;
      act_en_reg     <= 4'h0;
      shd_value_reg  <= 16'h0000;
      shd_dp_reg     <= 4'h0;
      shd_en_reg     <= 4'h0;
      pending_reg    <= 1'b0;
      digit_reg      <= 4'h0;
      anode_reg      <= 4'hF;
      dp_reg         <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      sel_reg        <= sel_next;
      act_value_reg  <= act_value_next;
      act_dp_reg     <= act_dp_next;
      act_en_reg     <= act_en_next;
      shd_value_reg  <= shd_value_next;
      shd_dp_reg     <= shd_dp_next;
      shd_en_reg     <= shd_en_next;
      pending_reg    <= pending_next;
      digit_reg      <= digit_next;
      anode_reg      <= anode_next;
      dp_reg         <= dp_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign pending    = pending_reg;
  assign digit      = digit_reg;
  assign anode      = anode_reg;
  assign dp         = dp_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: scoreboard bench for sevenseg_scan with 4-clock slots.
// The stimulus process predicts each cycle's outputs from frame-level rules
// (edge number -> slot, last load before a boundary -> frame contents) and
// queues them; an independent monitor pops and compares every cycle.
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic        load;
  logic        pending;
  logic [3:0]  digit;
  logic [3:0]  anode;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  sevenseg_scan #(.DIV_WIDTH(4), .DIV_MAX(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .load       (load),
    .pending    (pending),
    .digit      (digit),
    .anode      (anode),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [3:0] digit;
    logic [3:0] anode;
    logic       dp;
    logic       frame_tick;
    logic       pending;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state (frame-level view, not a copy of the RTL).
  int          k;            // clock edges since reset release
  logic [15:0] m_value;      // frame contents on display
  logic [3:0]  m_dp;
  logic [3:0]  m_en;
  logic [15:0] l_value;      // most recent load not yet shown
  logic [3:0]  l_dp;
  logic [3:0]  l_en;
  logic        l_waiting;
  exp_t        m_out;
  logic        cur_blz;

  task automatic model_reset();
    k         = 0;
    m_value   = '0; m_dp = '0; m_en = '0;
    l_value   = '0; l_dp = '0; l_en = '0;
    l_waiting = 1'b0;
    m_out     = '{digit: 4'h0, anode: 4'hF, dp: 1'b1, frame_tick: 1'b0, pending: 1'b0};
    sb_q.delete();
  endtask

  // One clock: drive inputs on the falling edge, predict the result of the
  // following rising edge and queue it for the monitor.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] d,
                       input logic [3:0] e, input logic blz);
    int  s;
    logic vis;
    logic [15:0] upper;
    @(negedge clk);
    load = ld; value = v; dp_in = d; digit_en = e; blank_lz = blz;
    @(posedge clk);
    k++;
    if (ld) begin
      l_value = v; l_dp = d; l_en = e; l_waiting = 1'b1;
      $display("[%0t] load value=%h dp=%b en=%b edge=%0d", $time, v, d, e, k);
    end
    m_out.frame_tick = (k % 16 == 0);
    if (k % 16 == 0 && l_waiting) begin
      m_value = l_value; m_dp = l_dp; m_en = l_en; l_waiting = 1'b0;
    end
    if (k % 4 == 0) begin
      s     = (k / 4) % 4;
      upper = m_value >> (4 * s);
      vis   = m_en[s] && !(blz && s > 0 && upper == 16'h0);
      m_out.digit = upper[3:0];
      m_out.anode = vis ? 4'(~(1 << s)) : 4'hF;
      m_out.dp    = vis ? ~m_dp[s] : 1'b1;
    end
    m_out.pending = l_waiting;
    sb_q.push_back(m_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), cur_blz);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    cycle(1'b1, v, d, e, cur_blz);
  endtask

  // Wait until the next edge is edge number n modulo 16.
  task automatic align(input int n);
    while ((k + 1) % 16 != n) idle(1);
  endtask

  task automatic check_dark(input string name);
    checks++;
    if (anode !== 4'hF || dp !== 1'b1 || pending !== 1'b0 ||
        frame_tick !== 1'b0 || digit !== 4'h0) begin
      failures++;
      $display("FAIL %s: got anode=%b dp=%b pending=%b ftick=%b digit=%h, need anode=1111 dp=1 pending=0 ftick=0 digit=0",
               name, anode, dp, pending, frame_tick, digit);
    end
  endtask

  // Reset asserted between clock edges; the display must go dark at once.
  task automatic reset_mid(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    load = 1'b0;
    #1 check_dark(name);
    model_reset();
    $display("[%0t] reset asserted (%s)", $time, name);
    repeat (2) @(posedge clk);
    #1 check_dark({name, "_hold"});
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: compare every rising-edge result against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({digit, anode, dp, frame_tick, pending} !== e) begin
          failures++;
          $display("FAIL scan_out t=%0t: got digit=%h anode=%b dp=%b ftick=%b pending=%b, need digit=%h anode=%b dp=%b ftick=%b pending=%b",
                   $time, digit, anode, dp, frame_tick, pending,
                   e.digit, e.anode, e.dp, e.frame_tick, e.pending);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; digit_en = '0; blank_lz = 1'b0;
    cur_blz = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_dark("reset_state");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic load and scan; dark until the first frame boundary.
    do_load(16'h1234, 4'h0, 4'hF);
    idle(40);

    // Leading-zero blanking.
    cur_blz = 1'b1;
    do_load(16'h0050, 4'h0, 4'hF);
    idle(36);
    do_load(16'h0000, 4'h0, 4'hF);
    idle(36);
    cur_blz = 1'b0;

    // Double buffering: load mid-frame, and last load wins.
    do_load(16'h1234, 4'h0, 4'hF);
    idle(20);
    align(10);
    do_load(16'hABCD, 4'h0, 4'hF);
    idle(36);
    align(3);
    do_load(16'h1111, 4'h0, 4'hF);
    idle(3);
    do_load(16'h2222, 4'h0, 4'hF);
    idle(36);

    // Load exactly on the boundary edge.
    align(0);
    do_load(16'h9870, 4'h0, 4'hF);
    idle(20);

    // Decimal points with a disabled slot, then all enabled.
    do_load(16'h4321, 4'b0100, 4'b1011);
    idle(36);
    do_load(16'h4321, 4'b0100, 4'hF);
    idle(36);

    // Reset mid-slot with data pending; display dark until new load.
    align(7);
    do_load(16'h5555, 4'hF, 4'hF);
    idle(1);
    reset_mid("reset_mid");
    idle(36);
    do_load(16'h6789, 4'h1, 4'hF);
    idle(20);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] v;
      if ($urandom_range(0, 63) == 0) cur_blz = ~cur_blz;
      v = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      if (i == 700) reset_mid("reset_rand");
      cycle($urandom_range(0, 9) == 0, v, 4'($urandom), 4'($urandom), cur_blz);
    end
    idle(2);

    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d queued, need 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
